// File: rtl/jtag_seq_driver.sv
// rtl/jtag_seq_driver.sv - command-driven TMS/TDI sequencer for a JTAG TAP
//
// Purpose: turns RESET / SHIFT_IR / SHIFT_DR / IDLE command words into the
// TMS/TDI streams that walk a downstream TAP, and returns the TDO bits seen
// during shifts as a response word. All state advances on the falling edge
// of TCK so the TAP sees stable TMS/TDI on its rising edge.
//
// Ports:
//   TCK, TRST          test clock (falling-edge state) and async active-high reset
//   cmd_valid/ready    command handshake; cmd_type/len/data latched on accept
//   TMS, TDI, TDO      TAP-facing serial pins
//   rsp_valid          one-cycle completion pulse
//   rsp_data           captured TDO bits, bit i from shift cycle i
module jtag_seq_driver #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH) + 1
) (
    input  logic             TCK,
    input  logic             TRST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_type,
    input  logic [LW-1:0]    cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             TMS,
    output logic             TDI,
    input  logic             TDO,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // Counter must hold the 6-cycle RESET walk even for tiny WIDTH.
    localparam int CW = (LW > 3) ? LW : 3;

    localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    localparam logic [1:0] CMD_RESET = 2'd0;
    localparam logic [1:0] CMD_IR    = 2'd1;
    localparam logic [1:0] CMD_DR    = 2'd2;
    localparam logic [1:0] CMD_IDLE  = 2'd3;

    typedef enum logic [3:0] {
        S_INIT,
        S_READY,
        S_LOAD,
        S_RESET,
        S_IDLE,
        S_SEL,
        S_CAP,
        S_ENTER,
        S_SHIFT,
        S_UPDATE,
        S_RTI
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       type_q, type_d;
    logic [LW-1:0]    len_q, len_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic [IW-1:0]    bit_idx;
    logic [CW-1:0]    len_c;
    logic             cmd_is_shift;

    assign bit_idx      = cnt_q[IW-1:0];
    assign len_c        = CW'(len_q);
    assign cmd_is_shift = (cmd_type == CMD_IR) || (cmd_type == CMD_DR);

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            state_q     <= S_INIT;
            type_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            cap_q       <= cap_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        cap_d       = cap_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        cmd_ready   = 1'b0;
        TMS         = 1'b0;
        TDI         = 1'b0;

        case (state_q)
            // TAP leaves Test-Logic-Reset on this cycle's TMS=0.
            S_INIT: state_d = S_READY;

            S_READY: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = S_LOAD;
                    type_d  = cmd_type;
                    data_d  = cmd_data;
                    len_d   = (cmd_is_shift && (cmd_len > WIDTH_L)) ? WIDTH_L : cmd_len;
                end
            end

            // Decode cycle: TAP idles in Run-Test/Idle while the walk is set up.
            S_LOAD: begin
                cap_d = '0;
                case (type_q)
                    CMD_RESET: begin
                        state_d = S_RESET;
                        cnt_d   = CW'(6);
                    end
                    CMD_IDLE: begin
                        state_d = S_IDLE;
                        cnt_d   = (len_q == '0) ? ONE_C : len_c;
                    end
                    CMD_IR, CMD_DR: begin
                        if (len_q == '0) begin
                            state_d     = S_READY;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = '0;
                        end else begin
                            state_d = S_SEL;
                            // IR walks through Select-DR and Select-IR.
                            cnt_d   = (type_q == CMD_IR) ? CW'(2) : ONE_C;
                        end
                    end
                endcase
            end

            // Five TMS=1 cycles reach Test-Logic-Reset from anywhere; the last
            // cycle drops TMS to land in Run-Test/Idle.
            S_RESET: begin
                TMS = (cnt_q != ONE_C);
                if (cnt_q == ONE_C) begin
                    state_d     = S_READY;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end

            S_IDLE: begin
                if (cnt_q == ONE_C) begin
                    state_d     = S_READY;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end

            S_SEL: begin
                TMS = 1'b1;
                if (cnt_q == ONE_C) begin
                    state_d = S_CAP;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end

            S_CAP: state_d = S_ENTER;

            S_ENTER: begin
                state_d = S_SHIFT;
                cnt_d   = '0;
            end

            // cnt_q is the shift index; TDO for this cycle is taken at the
            // falling edge that ends it.
            S_SHIFT: begin
                TDI            = data_q[bit_idx];
                cap_d[bit_idx] = TDO;
                if (cnt_q == (len_c - ONE_C)) begin
                    TMS     = 1'b1;
                    state_d = S_UPDATE;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end

            S_UPDATE: begin
                TMS     = 1'b1;
                state_d = S_RTI;
            end

            S_RTI: begin
                state_d     = S_READY;
                rsp_valid_d = 1'b1;
                rsp_data_d  = cap_q;
            end

            default: state_d = S_INIT;
        endcase
    end
endmodule

// File: tb/tb_jtag_seq_driver.sv
// tb/tb_jtag_seq_driver.sv - self-checking bench for jtag_seq_driver
module tb_jtag_seq_driver;
    localparam int WIDTH = 8;
    localparam int LW    = 4;

    logic             TCK = 1'b0;
    logic             TRST = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_type = 2'd0;
    logic [LW-1:0]    cmd_len = '0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             TMS;
    logic             TDI;
    logic             TDO = 1'b0;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;
    int tdo_mode = 0;   // 0 tie low, 1 tie high, 2 loopback TAP, 3 random

    jtag_seq_driver #(.WIDTH(WIDTH), .LW(LW)) dut (
        .TCK(TCK), .TRST(TRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .TMS(TMS), .TDI(TDI), .TDO(TDO),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    always #5 TCK = ~TCK;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Behavioural TAP: state tracker plus an 8-bit pass-through data register.
    typedef enum logic [3:0] {TLR, RTI, SDS, CDR, SDR, E1D, PDR, E2D, UDR,
                              SIS, CIR, SIR, E1I, PIR, E2I, UIR} tap_t;
    tap_t       tap_st;
    logic [7:0] tap_dr = 8'h00;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR: return m ? TLR : RTI;
            RTI: return m ? SDS : RTI;
            SDS: return m ? SIS : CDR;
            CDR: return m ? E1D : SDR;
            SDR: return m ? E1D : SDR;
            E1D: return m ? UDR : PDR;
            PDR: return m ? E2D : PDR;
            E2D: return m ? UDR : SDR;
            UDR: return m ? SDS : RTI;
            SIS: return m ? TLR : CIR;
            CIR: return m ? E1I : SIR;
            SIR: return m ? E1I : SIR;
            E1I: return m ? UIR : PIR;
            PIR: return m ? E2I : PIR;
            E2I: return m ? UIR : SIR;
            UIR: return m ? SDS : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            tap_st <= TLR;
        end else begin
            if (tap_st == SDR) tap_dr <= {TDI, tap_dr[7:1]};
            tap_st <= tap_next(tap_st, TMS);
        end
    end

    always @(negedge TCK) begin
        #1;
        case (tdo_mode)
            0: TDO = 1'b0;
            1: TDO = 1'b1;
            2: TDO = (tap_st == SDR) ? tap_dr[0] : 1'b0;
            default: TDO = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge TCK);
        #1;
    endtask

    task automatic sample();
        @(posedge TCK);
        #1;
    endtask

    // Observations of the most recent command.
    logic [63:0] ob_tms, ob_tdi, ob_tdo;
    int          ob_lat;
    logic [7:0]  ob_rsp;
    logic        ob_rti, ob_pulse_ok;

    // Entered and left just after a falling edge.
    task automatic exec_cmd(input logic [1:0] t, input logic [3:0] len,
                            input logic [7:0] d, input int mode);
        int w;
        tdo_mode  = mode;
        cmd_type  = t;
        cmd_len   = len;
        cmd_data  = d;
        cmd_valid = 1'b1;
        w = 0;
        sample();
        while (!cmd_ready && w < 50) begin
            next_cycle();
            sample();
            w++;
        end
        check("accept_ready", 64'(cmd_ready), 64'd1);
        next_cycle();
        cmd_valid = 1'b0;
        cmd_type  = 2'($urandom);
        cmd_len   = 4'($urandom);
        cmd_data  = 8'($urandom);
        ob_tms = '0; ob_tdi = '0; ob_tdo = '0;
        ob_lat = -1; ob_rsp = '0; ob_rti = 1'b0; ob_pulse_ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            sample();
            if (rsp_valid) begin
                ob_lat = k;
                ob_rsp = rsp_data;
                ob_rti = (tap_st == RTI) && cmd_ready;
                break;
            end
            ob_tms[k] = TMS;
            ob_tdi[k] = TDI;
            ob_tdo[k] = TDO;
            next_cycle();
        end
        next_cycle();
        sample();
        ob_pulse_ok = !rsp_valid && cmd_ready && (rsp_data == ob_rsp);
        next_cycle();
    endtask

    // Reference: TMS/TDI per cycle after the accept edge, from the command rules.
    function automatic void ref_model(input logic [1:0] t, input int len, input logic [7:0] d,
                                      output logic [63:0] tms, output logic [63:0] tdi,
                                      output int lat, output int sh0, output int n);
        bit q[$];
        tms = '0; tdi = '0; sh0 = 0; n = 0;
        q.push_back(1'b0);
        case (t)
            2'd0: begin
                repeat (5) q.push_back(1'b1);
                q.push_back(1'b0);
            end
            2'd3: repeat ((len == 0) ? 1 : len) q.push_back(1'b0);
            default: begin
                n = (len > WIDTH) ? WIDTH : len;
                if (n > 0) begin
                    repeat ((t == 2'd1) ? 2 : 1) q.push_back(1'b1);
                    q.push_back(1'b0);
                    q.push_back(1'b0);
                    sh0 = q.size();
                    for (int i = 0; i < n; i++) begin
                        tdi[sh0 + i] = d[i];
                        q.push_back(i == n - 1);
                    end
                    q.push_back(1'b1);
                    q.push_back(1'b0);
                end
            end
        endcase
        lat = q.size();
        for (int i = 0; i < q.size(); i++) tms[i] = q[i];
    endfunction

    typedef struct {
        logic [1:0]  t;
        logic [3:0]  len;
        logic [7:0]  d;
        int          mode;
        logic [63:0] tms;
        logic [63:0] tdi;
        int          lat;
        logic [7:0]  rsp;
    } vec_t;

    vec_t vt[11];

    logic [63:0] m_tms, m_tdi;
    int          m_lat, m_sh0, m_n;
    logic [7:0]  m_rsp;
    logic [1:0]  r_t;
    logic [3:0]  r_len;
    logic [7:0]  r_d;
    int          r_mode;
    int          w, k;
    logic        seen;
    int          b2b_lat[3];
    logic [7:0]  b2b_rsp[3];

    initial begin
        vt[0]  = '{2'd2, 4'd3,  8'h05, 0, 64'hC2,   64'h50,  9,  8'h00};
        vt[1]  = '{2'd1, 4'd5,  8'h15, 1, 64'h606,  64'h2A0, 12, 8'h1F};
        vt[2]  = '{2'd2, 4'd12, 8'hFF, 1, 64'h1802, 64'hFF0, 14, 8'hFF};
        vt[3]  = '{2'd2, 4'd8,  8'hA5, 2, 64'h1802, 64'hA50, 14, 8'hFF};
        vt[4]  = '{2'd2, 4'd8,  8'hA5, 2, 64'h1802, 64'hA50, 14, 8'hA5};
        vt[5]  = '{2'd0, 4'd0,  8'hFF, 1, 64'h3E,   64'h0,   7,  8'h00};
        vt[6]  = '{2'd3, 4'd0,  8'hFF, 1, 64'h0,    64'h0,   2,  8'h00};
        vt[7]  = '{2'd3, 4'd3,  8'hFF, 1, 64'h0,    64'h0,   4,  8'h00};
        vt[8]  = '{2'd2, 4'd0,  8'hFF, 1, 64'h0,    64'h0,   1,  8'h00};
        vt[9]  = '{2'd1, 4'd1,  8'h01, 1, 64'h66,   64'h20,  8,  8'h01};
        vt[10] = '{2'd3, 4'd15, 8'h00, 0, 64'h0,    64'h0,   16, 8'h00};

        // Reset and INIT.
        #2 TRST = 1'b1;
        repeat (2) begin
            sample();
            check("reset_outputs", 64'({TMS, TDI, cmd_ready, rsp_valid, rsp_data}), 64'd0);
        end
        next_cycle();
        TRST = 1'b0;
        sample();
        check("init_cycle", 64'({cmd_ready, TMS}), 64'd0);
        next_cycle();
        sample();
        check("ready_after_init", 64'({cmd_ready, TMS, rsp_valid}), 64'b100);
        check("tap_rti_after_init", 64'(tap_st == RTI), 64'd1);
        next_cycle();

        // Directed vectors.
        for (int i = 0; i < 11; i++) begin
            exec_cmd(vt[i].t, vt[i].len, vt[i].d, vt[i].mode);
            check($sformatf("v%0d_tms", i), ob_tms, vt[i].tms);
            check($sformatf("v%0d_tdi", i), ob_tdi, vt[i].tdi);
            check($sformatf("v%0d_lat", i), 64'(ob_lat), 64'(vt[i].lat));
            check($sformatf("v%0d_rsp", i), 64'(ob_rsp), 64'(vt[i].rsp));
            check($sformatf("v%0d_rti", i), 64'(ob_rti), 64'd1);
            check($sformatf("v%0d_pulse", i), 64'(ob_pulse_ok), 64'd1);
        end

        // Randomized commands against the reference model.
        for (int i = 0; i < 40; i++) begin
            r_t    = 2'($urandom_range(0, 3));
            r_len  = 4'($urandom_range(0, 15));
            r_d    = 8'($urandom);
            r_mode = $urandom_range(0, 2);
            if (r_mode == 2) r_mode = 3;
            repeat ($urandom_range(0, 2)) next_cycle();
            exec_cmd(r_t, r_len, r_d, r_mode);
            ref_model(r_t, int'(r_len), r_d, m_tms, m_tdi, m_lat, m_sh0, m_n);
            m_rsp = '0;
            for (int b = 0; b < m_n; b++) m_rsp[b] = ob_tdo[m_sh0 + b];
            check($sformatf("r%0d_tms t=%0d len=%0d", i, r_t, r_len), ob_tms, m_tms);
            check($sformatf("r%0d_tdi", i), ob_tdi, m_tdi);
            check($sformatf("r%0d_lat", i), 64'(ob_lat), 64'(m_lat));
            check($sformatf("r%0d_rsp", i), 64'(ob_rsp), 64'(m_rsp));
            check($sformatf("r%0d_rti", i), 64'(ob_rti), 64'd1);
            check($sformatf("r%0d_pulse", i), 64'(ob_pulse_ok), 64'd1);
        end

        // Back-to-back: cmd_valid held, each accept on the predecessor's rsp_valid edge.
        b2b_lat[0] = 3; b2b_lat[1] = 7; b2b_lat[2] = 8;
        b2b_rsp[0] = 8'h00; b2b_rsp[1] = 8'h00; b2b_rsp[2] = 8'h03;
        tdo_mode  = 1;
        cmd_type  = 2'd3;
        cmd_len   = 4'd2;
        cmd_data  = 8'h00;
        cmd_valid = 1'b1;
        w = 0;
        sample();
        while (!cmd_ready && w < 50) begin
            next_cycle();
            sample();
            w++;
        end
        check("b2b_first_ready", 64'(cmd_ready), 64'd1);
        for (int j = 0; j < 3; j++) begin
            next_cycle();
            if (j == 0) begin
                cmd_type = 2'd0;
                cmd_len  = 4'($urandom);
                cmd_data = 8'($urandom);
            end else if (j == 1) begin
                cmd_type = 2'd2;
                cmd_len  = 4'd2;
                cmd_data = 8'h03;
            end else begin
                cmd_valid = 1'b0;
            end
            k = 0;
            sample();
            while (!rsp_valid && k < 40) begin
                next_cycle();
                sample();
                k++;
            end
            check($sformatf("b2b%0d_lat", j), 64'(k), 64'(b2b_lat[j]));
            check($sformatf("b2b%0d_ready_with_rsp", j), 64'(cmd_ready), 64'd1);
            check($sformatf("b2b%0d_rsp", j), 64'(rsp_data), 64'(b2b_rsp[j]));
        end
        next_cycle();

        // TRST during shift cycle 2 of a DR shift.
        cmd_type  = 2'd2;
        cmd_len   = 4'd6;
        cmd_data  = 8'h2D;
        cmd_valid = 1'b1;
        w = 0;
        sample();
        while (!cmd_ready && w < 50) begin
            next_cycle();
            sample();
            w++;
        end
        check("abort_accept", 64'(cmd_ready), 64'd1);
        next_cycle();
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            sample();
            seen |= rsp_valid;
            next_cycle();
        end
        sample();
        check("abort_shift2_pins", 64'({TMS, TDI}), 64'b01);
        TRST = 1'b1;
        #1;
        check("abort_reset_values", 64'({TMS, TDI, cmd_ready, rsp_valid, rsp_data}), 64'd0);
        repeat (2) begin
            next_cycle();
            sample();
            seen |= rsp_valid;
        end
        next_cycle();
        TRST = 1'b0;
        sample();
        seen |= rsp_valid;
        check("abort_init_cycle", 64'({cmd_ready, TMS}), 64'd0);
        next_cycle();
        sample();
        seen |= rsp_valid;
        check("abort_ready_after", 64'(cmd_ready), 64'd1);
        check("abort_no_rsp", 64'(seen), 64'd0);
        check("abort_tap_rti", 64'(tap_st == RTI), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jtag_seq_driver.md
Name: jtag_seq_driver

Overview:
- Command-driven JTAG sequencer that sits directly upstream of jtag_tap.
- Turns simple command words (reset, shift IR, shift DR, idle) into the TMS/TDI bit streams that walk the TAP state machine.
- Captures TDO during shifts and returns the captured bits as a response word.
- Used by on-chip test logic and benches, so they never hand-toggle TMS.

Parameters:
- WIDTH, 8, maximum shift length in bits; width of cmd_data and rsp_data.
- LW, $clog2(WIDTH)+1, width of cmd_len.

Ports:
- TCK  in  1  JTAG test clock; the only clock. All state updates on the falling edge.
- TRST  in  1  asynchronous, active-high reset; also wired to jtag_tap TRST.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_type  in  2  0=RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=IDLE.
- cmd_len  in  LW  bit count (shift) or cycle count (IDLE).
- cmd_data  in  WIDTH  TDI bits, LSB shifted first.
- TMS  out  1  to jtag_tap TMS.
- TDI  out  1  to jtag_tap TDI.
- TDO  in  1  from jtag_tap TDO.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  WIDTH  captured TDO bits; bit i = TDO sampled in shift cycle i.

Behaviour:
- Reset (TRST=1, async):
  - TMS=0, TDI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, state=INIT.
  - The TAP is in Test-Logic-Reset at the same time.
- Timing convention:
  - TMS/TDI change only after falling edges; jtag_tap samples them on rising edges.
  - "Cycle k" = the TCK period following falling edge k.
- INIT: one cycle with TMS=0 (TLR→RTI), then READY.
- READY:
  - cmd_ready=1, TMS=0, TDI=0.
  - Handshake completes on a falling edge with cmd_valid&cmd_ready; cmd_type/len/data are latched there.
  - cmd_ready drops the following cycle.
- Length rules:
  - Shift len > WIDTH is clamped to WIDTH.
  - Shift len = 0: no TAP traversal. The next cycle is rsp_valid=1, rsp_data=0, back in READY.
- SHIFT_DR, N bits (TMS per cycle after accept): 1 (SelDR), 0 (Capture), 0 (→Shift), then N shift cycles with TMS=0…0,1 (last → Exit1), then 1 (Update), 0 (→RTI).
- SHIFT_IR: same sequence with an extra leading 1 (SelDR→SelIR).
- Shift-cycle data:
  - During shift cycle i (0..N-1), TDI=cmd_data[i].
  - TDO is sampled into rsp_data[i] at the falling edge ending that cycle.
  - Unshifted rsp_data bits are 0.
  - Outside shift cycles, TDI=0.
- RESET: TMS=1,1,1,1,1, then 0; rsp_data=0.
- IDLE: TMS=0 for max(cmd_len,1) cycles; rsp_data=0.
- Completion:
  - In the cycle after the final sequence cycle, rsp_valid=1 for exactly one cycle and cmd_ready=1 (READY).
  - A command accepted at that same falling edge starts immediately (back-to-back, no bubble).
  - rsp_data holds until the next completion updates it. There is no response backpressure.
- Latency, accept edge to rsp_valid cycle: DR = N+6 cycles, IR = N+7, RESET = 7, IDLE = max(len,1)+1.
- TRST mid-command: abort immediately to INIT with reset values. No rsp_valid for the aborted command.
- cmd_valid ignored whenever cmd_ready=0; cmd_* may change freely after acceptance.

Test Plan:
1. TRST=1 for 2 cycles, release → one TMS=0 cycle, then cmd_ready=1; all outputs at reset values during TRST.
2. SHIFT_DR len=3 data=3'b101, TDO=0 → TMS trace 1,0,0,0,0,1,1,0; TDI=1,0,1 in shift cycles only; rsp_valid 9 cycles after accept; rsp_data=0x00.
3. SHIFT_IR len=5 data=0x15, TDO tied 1 → TMS 1,1,0,0,0,0,0,0,1,1,0; rsp_data=0x1F.
4. Loopback with real jtag_tap (WIDTH=8): SHIFT_DR len=8 data=0xA5 twice → second rsp_data equals the TAP's shifted-out value, 0xA5 for a pass-through register; TAP returns to RTI after each command.
5. Edge lengths: len=0 → rsp_valid next cycle, no TMS activity; len=12 → clamped to 8 shift cycles; IDLE len=0 → 1 TMS=0 cycle.
6. cmd_valid held high with 3 queued commands → each accepted on its predecessor's rsp_valid edge. Then assert TRST in shift cycle 2 → immediate reset values, no rsp_valid, INIT then READY after release.
